// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer and its hazard logic.
// Holds the sequencer state encoding, the default drain length, the register-index
// width and the register-zero constant.
package pipe_ctrl_pkg;

   localparam int unsigned DRAIN_CYCLES_DEF = 3;
   localparam int unsigned REG_IDX_W        = 5;

   localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_STEP,
      ST_DRAIN,
      ST_HALTED
   } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Flags an instruction in ID that reads the destination of a load still in EX.
// The register-zero destination never creates a hazard.
// Ports:
//   i_ex_mem_read - instruction in EX is a load
//   i_ex_rt       - load destination register
//   i_id_rs       - rs source of the instruction in ID
//   i_id_rt       - rt source of the instruction in ID
//   o_load_use    - hazard present this cycle
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic                 i_ex_mem_read,
   input  logic [REG_IDX_W-1:0] i_ex_rt,
   input  logic [REG_IDX_W-1:0] i_id_rs,
   input  logic [REG_IDX_W-1:0] i_id_rt,
   output logic                 o_load_use
);

   always_comb begin
      o_load_use = i_ex_mem_read && (i_ex_rt != REG_ZERO) &&
                   ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB latches.
// Turns debug run/step/pause commands, load-use hazards and taken branches into
// per-cycle enables, flushes and bubbles. A HALT seen in ID drains the pipe for
// DRAIN_CYCLES cycles, then a sticky halted state holds until reset.
// Enables are combinational from state and current inputs; state and counters
// are registered. Reset rst is synchronous, active-low.
// Ports:
//   clk, rst                          - clock, synchronous active-low reset
//   i_cmd_run/i_cmd_step/i_cmd_pause  - debug command pulses
//   i_id_halt                         - HALT decoded in ID
//   i_id_rs, i_id_rt                  - ID source register fields
//   i_ex_mem_read, i_ex_rt            - load in EX and its destination
//   i_branch_taken                    - branch resolved taken in ID
//   o_pc_en, o_ifid_en, o_ifid_flush  - front-end controls
//   o_idex_bubble, o_pipe_en          - back-end controls
//   o_halted                          - program finished
//   o_cycle_count                     - saturating active-cycle counter
//   o_stall_count                     - saturating load-use stall counter
//                                       (present only with PIPE_CTRL_STALL_CNT_EN)
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_cmd_run,
   input  logic                 i_cmd_step,
   input  logic                 i_cmd_pause,
   input  logic                 i_id_halt,
   input  logic [REG_IDX_W-1:0] i_id_rs,
   input  logic [REG_IDX_W-1:0] i_id_rt,
   input  logic                 i_ex_mem_read,
   input  logic [REG_IDX_W-1:0] i_ex_rt,
   input  logic                 i_branch_taken,
   output logic                 o_pc_en,
   output logic                 o_ifid_en,
   output logic                 o_ifid_flush,
   output logic                 o_idex_bubble,
   output logic                 o_pipe_en,
   output logic                 o_halted,
   output logic [CNT_W-1:0]     o_cycle_count
`ifdef PIPE_CTRL_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]     o_stall_count
`endif
);

   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   state_e               state_q, state_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic [CNT_W-1:0]     cycle_q, cycle_d;
   logic                 load_use;
   logic                 exec_c;
   logic                 stall_c;

   hazard_detect u_hazard (
      .i_ex_mem_read (i_ex_mem_read),
      .i_ex_rt       (i_ex_rt),
      .i_id_rs       (i_id_rs),
      .i_id_rt       (i_id_rt),
      .o_load_use    (load_use)
   );

   // Hazards only matter while instructions are actually issuing.
   assign exec_c  = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign stall_c = exec_c && load_use;

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         drain_q <= '0;
         cycle_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         cycle_q <= cycle_d;
      end
   end

   // Next state and per-cycle pipeline controls.
   always_comb begin
      state_d       = state_q;
      drain_d       = drain_q;
      cycle_d       = cycle_q;
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_ifid_flush  = 1'b0;
      o_idex_bubble = 1'b0;
      o_pipe_en     = 1'b0;
      o_halted      = 1'b0;

      if (exec_c) begin
         o_pipe_en     = 1'b1;
         o_pc_en       = !stall_c;
         o_ifid_en     = !stall_c;
         o_idex_bubble = stall_c;
         o_ifid_flush  = i_branch_taken && !stall_c;
      end

      case (state_q)
         ST_IDLE: begin
            if (i_cmd_run) begin
               state_d = ST_RUN;
            end else if (i_cmd_step) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            // A halt seen during a stall is re-presented next cycle.
            if (i_id_halt && !stall_c) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_W'(DRAIN_CYCLES);
            end else if (i_cmd_pause) begin
               state_d = ST_IDLE;
            end
         end
         ST_STEP: begin
            if (i_id_halt && !stall_c) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_W'(DRAIN_CYCLES);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // Fetch is frozen and IF/ID held at NOP while older work retires.
            o_pipe_en    = 1'b1;
            o_ifid_flush = 1'b1;
            drain_d      = drain_q - DRAIN_W'(1);
            if (drain_q == DRAIN_W'(1)) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            o_halted = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (o_pipe_en && (cycle_q != '1)) begin
         cycle_d = cycle_q + CNT_W'(1);
      end
   end

   assign o_cycle_count = cycle_q;

`ifdef PIPE_CTRL_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of load-use stall cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_c && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_stall_count = stall_cnt_q;
`endif

endmodule
